// File: rtl/riscv_pkg.sv
// Shared fetch-stage constants and the fetch FSM state type.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package riscv_pkg;

  // addi x0,x0,0 -- presented to decode whenever no real instruction is held
  localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC  = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_TRAP = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/pc_next_logic.sv
// Next-PC selection: PC+4 adder, taken-target mux and misaligned-target detect.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the result is consumed.
module pc_next_logic
  import riscv_pkg::*;
(
  input  logic [31:0] pc,
  input  logic        pcsrc,
  input  logic [31:0] pctarget,
  output logic [31:0] pc_plus4,
  output logic [31:0] pc_next,
  output logic        target_misalign
);

  // adder wraps naturally at 2^32; a taken target must be word aligned
  always_comb begin
    pc_plus4        = pc + 32'd4;
    pc_next         = pcsrc ? pctarget : pc_plus4;
    target_misalign = pcsrc & (pctarget[1:0] != 2'b00);
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: holds PC, fetches over req/ready + rvalid, presents Instr/PC to decode.
// Latency: best case 3 cycles per instruction (request, wait for data, hold for accept).
// Backpressure: request held until imem_ready; instruction held stable until instr_accept.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        PCSrc,
  input  logic [31:0] PCTarget,
  input  logic        instr_accept,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] Instr,
  output logic [31:0] PC,
  output logic [31:0] PCPlus4,
  output logic        misalign,
  output logic [31:0] retire_count
);

  fetch_state_t state, state_next;
  logic [31:0]  pc_next;
  logic         target_misalign;
  logic         accept_hold;
  logic         trap_take;

  pc_next_logic u_pc_next (
    .pc              (PC),
    .pcsrc           (PCSrc),
    .pctarget        (PCTarget),
    .pc_plus4        (PCPlus4),
    .pc_next         (pc_next),
    .target_misalign (target_misalign)
  );

  assign imem_addr   = PC;
  assign accept_hold = (state == S_HOLD) && instr_accept;
  assign trap_take   = accept_hold && target_misalign;

  // state register; reset may land mid-transaction, any in-flight read is simply forgotten
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_REQ;
    else       state <= state_next;
  end

  // next-state: grant and read data are taken in different states, so never in one cycle
  always_comb begin
    state_next = state;
    case (state)
      S_REQ:  if (imem_ready)   state_next = S_WAIT;
      S_WAIT: if (imem_rvalid)  state_next = S_HOLD;
      S_HOLD: if (instr_accept) state_next = target_misalign ? S_TRAP : S_REQ;
      S_TRAP: state_next = S_TRAP;
      default: state_next = S_REQ;
    endcase
  end

  // registered outputs: req/valid are Moore flags precomputed from next state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      PC           <= RESET_PC;
      Instr        <= NOP_INSTR;
      instr_valid  <= 1'b0;
      imem_req     <= 1'b0;
      misalign     <= 1'b0;
      retire_count <= 32'd0;
    end else begin
      imem_req    <= (state_next == S_REQ);
      instr_valid <= (state_next == S_HOLD);
      if ((state == S_WAIT) && imem_rvalid) begin
        Instr <= imem_rdata;
      end
      if (accept_hold) begin
        retire_count <= retire_count + 32'd1;
        Instr        <= NOP_INSTR;
        if (trap_take) misalign <= 1'b1;
        else           PC       <= pc_next;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        PCSrc;
  logic [31:0] PCTarget;
  logic        instr_accept;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] Instr;
  logic [31:0] PC;
  logic [31:0] PCPlus4;
  logic        misalign;
  logic [31:0] retire_count;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;

  fetch_unit dut (
    .clk          (clk),
    .reset        (reset),
    .PCSrc        (PCSrc),
    .PCTarget     (PCTarget),
    .instr_accept (instr_accept),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .instr_valid  (instr_valid),
    .Instr        (Instr),
    .PC           (PC),
    .PCPlus4      (PCPlus4),
    .misalign     (misalign),
    .retire_count (retire_count)
  );

  always #5 clk = ~clk;

  // one clock, then settle 1 time unit past the edge before looking/driving
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    PCSrc        = 1'b0;
    PCTarget     = 32'h0;
    instr_accept = 1'b0;
    imem_ready   = 1'b0;
    imem_rvalid  = 1'b0;
    imem_rdata   = 32'h0;
  endtask

  // from S_REQ: grant immediately, data one cycle later -> ends in S_HOLD
  task automatic fetch_one(input logic [31:0] data);
    imem_ready = 1'b1;
    step();
    imem_ready  = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = data;
    step();
    imem_rvalid = 1'b0;
  endtask

  task automatic accept_one(input logic src, input logic [31:0] tgt);
    PCSrc        = src;
    PCTarget     = tgt;
    instr_accept = 1'b1;
    step();
    instr_accept = 1'b0;
    PCSrc        = 1'b0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    reset = 1'b1;
    step(); step(); step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (PC !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h want %h", PC, 32'h0); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
    checks++; if (Instr !== NOP) begin errors++; $display("FAIL reset_instr: got %h want %h", Instr, NOP); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", imem_req); end
    checks++; if (misalign !== 1'b0 || retire_count !== 32'h0) begin errors++; $display("FAIL reset_misc: misalign %b retire %h want 0 0", misalign, retire_count); end
    step();
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL reset_req_rise: got %b want 1", imem_req); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h want %h", imem_addr, 32'h0); end
  endtask

  task automatic test_sequential();
    imem_ready = 1'b1;
    step();
    imem_ready = 1'b0;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL seq_req_wait: got %b want 0", imem_req); end
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h0050_0093;
    step();
    imem_rvalid = 1'b0;
    checks++; if (instr_valid !== 1'b1 || Instr !== 32'h0050_0093) begin errors++; $display("FAIL seq_instr: valid %b instr %h want 1 00500093", instr_valid, Instr); end
    checks++; if (PC !== 32'h0 || PCPlus4 !== 32'h4) begin errors++; $display("FAIL seq_pc: pc %h pc4 %h want 0 4", PC, PCPlus4); end
    accept_one(1'b0, 32'h0);
    checks++; if (PC !== 32'h4 || retire_count !== 32'd1) begin errors++; $display("FAIL seq_after: pc %h retire %h want 4 1", PC, retire_count); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin errors++; $display("FAIL seq_req: req %b addr %h want 1 4", imem_req, imem_addr); end
    checks++; if (instr_valid !== 1'b0 || Instr !== NOP) begin errors++; $display("FAIL seq_nop: valid %b instr %h want 0 %h", instr_valid, Instr, NOP); end
  endtask

  task automatic test_branch();
    // walk 4 -> 8 -> C -> 10 sequentially
    for (int i = 0; i < 3; i++) begin
      fetch_one(32'h0000_0013);
      accept_one(1'b0, 32'h0);
    end
    fetch_one(32'h0400_006f);
    checks++; if (PC !== 32'h10 || instr_valid !== 1'b1) begin errors++; $display("FAIL br_pc10: pc %h valid %b want 10 1", PC, instr_valid); end
    accept_one(1'b1, 32'h40);
    checks++; if (imem_addr !== 32'h40 || imem_req !== 1'b1) begin errors++; $display("FAIL br_taken: addr %h req %b want 40 1", imem_addr, imem_req); end
    checks++; if (retire_count !== 32'd5) begin errors++; $display("FAIL br_retire: got %0d want 5", retire_count); end
    fetch_one(32'h0020_006f);
    accept_one(1'b1, 32'h42);
    checks++; if (misalign !== 1'b1) begin errors++; $display("FAIL br_misalign: got %b want 1", misalign); end
    checks++; if (PC !== 32'h40) begin errors++; $display("FAIL br_trap_pc: got %h want 40", PC); end
    // trap is terminal: memory activity and accepts are ignored
    imem_ready   = 1'b1;
    imem_rvalid  = 1'b1;
    instr_accept = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if (imem_req !== 1'b0 || instr_valid !== 1'b0 || PC !== 32'h40) begin errors++; $display("FAIL br_trap_hold: req %b valid %b pc %h want 0 0 40", imem_req, instr_valid, PC); end
    end
    idle_inputs();
  endtask

  task automatic test_backpressure();
    apply_reset();
    checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL bp_misalign_clr: got %b want 0", misalign); end
    step();
    for (int i = 0; i < 5; i++) begin
      step();
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL bp_req_hold: req %b addr %h want 1 0", imem_req, imem_addr); end
    end
    imem_ready = 1'b1;
    step();
    imem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if (imem_req !== 1'b0 || instr_valid !== 1'b0 || imem_addr !== 32'h0) begin errors++; $display("FAIL bp_wait: req %b valid %b addr %h want 0 0 0", imem_req, instr_valid, imem_addr); end
    end
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h00a0_0113;
    step();
    // spurious read data while holding must not disturb Instr
    imem_rdata = 32'hdead_beef;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (instr_valid !== 1'b1 || Instr !== 32'h00a0_0113 || PC !== 32'h0) begin errors++; $display("FAIL bp_hold: valid %b instr %h pc %h want 1 00a00113 0", instr_valid, Instr, PC); end
    end
    imem_rvalid = 1'b0;
    accept_one(1'b0, 32'h0);
    checks++; if (PC !== 32'h4 || retire_count !== 32'd1) begin errors++; $display("FAIL bp_accept: pc %h retire %h want 4 1", PC, retire_count); end
  endtask

  task automatic test_reset_mid_wait();
    imem_ready = 1'b1;
    step();
    imem_ready  = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h1234_5678;
    reset       = 1'b1;
    #1;
    checks++; if (PC !== 32'h0) begin errors++; $display("FAIL rst_async_pc: got %h want 0", PC); end
    step();
    checks++; if (instr_valid !== 1'b0 || Instr !== NOP) begin errors++; $display("FAIL rst_wait_instr: valid %b instr %h want 0 %h", instr_valid, Instr, NOP); end
    checks++; if (retire_count !== 32'h0 || imem_req !== 1'b0) begin errors++; $display("FAIL rst_wait_misc: retire %h req %b want 0 0", retire_count, imem_req); end
    reset = 1'b0;
    step();
    imem_rvalid = 1'b0;
    checks++; if (imem_req !== 1'b1 || Instr !== NOP || imem_addr !== 32'h0) begin errors++; $display("FAIL rst_restart: req %b instr %h addr %h want 1 %h 0", imem_req, Instr, imem_addr, NOP); end
  endtask

  task automatic test_wrap();
    fetch_one(32'h0000_0013);
    accept_one(1'b1, 32'hffff_fffc);
    checks++; if (PC !== 32'hffff_fffc || PCPlus4 !== 32'h0) begin errors++; $display("FAIL wrap_top: pc %h pc4 %h want fffffffc 0", PC, PCPlus4); end
    fetch_one(32'h0000_0013);
    accept_one(1'b0, 32'h0);
    checks++; if (PC !== 32'h0 || PCPlus4 !== 32'h4) begin errors++; $display("FAIL wrap_pc: pc %h pc4 %h want 0 4", PC, PCPlus4); end
    checks++; if (misalign !== 1'b0 || retire_count !== 32'd2) begin errors++; $display("FAIL wrap_misc: misalign %b retire %0d want 0 2", misalign, retire_count); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_sequential();
    test_branch();
    test_backpressure();
    test_reset_mid_wait();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
